// File: rtl/port_wr_frontend_if.sv
// Signal bundle between the packet source/matcher/SRAM side and port_wr_frontend.
interface port_wr_frontend_if;
  logic        wr_sop;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic        wr_eop;
  logic        busy;
  logic        match_enable;
  logic [5:0]  new_length;
  logic [3:0]  dest_port;
  logic        match_suc;
  logic [5:0]  match_best_sram;
  logic        xfer_vld;
  logic [4:0]  xfer_sram;
  logic [15:0] xfer_data;
  logic        xfer_last;
  logic        xfer_ready;
  logic        pkt_err;
  logic [15:0] pkt_cnt;

  modport slave (
    input  wr_sop, wr_vld, wr_data, wr_eop, match_suc, match_best_sram, xfer_ready,
    output busy, match_enable, new_length, dest_port, xfer_vld, xfer_sram,
           xfer_data, xfer_last, pkt_err, pkt_cnt
  );

  modport master (
    output wr_sop, wr_vld, wr_data, wr_eop, match_suc, match_best_sram, xfer_ready,
    input  busy, match_enable, new_length, dest_port, xfer_vld, xfer_sram,
           xfer_data, xfer_last, pkt_err, pkt_cnt
  );
endinterface

// File: rtl/port_wr_frontend.sv
// Write-port front end: buffers one packet, requests an SRAM match, then
// streams the buffered halfwords to the selected SRAM with valid/ready.
module port_wr_frontend (
  input  logic               clk,
  input  logic               rst_n,
  port_wr_frontend_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] MATCH = 2'd2;
  localparam logic [1:0] XFER  = 2'd3;

  logic [1:0]  state;
  logic [5:0]  len;
  logic [5:0]  wr_idx;
  logic [5:0]  rd_idx;
  logic [5:0]  rd_next;
  logic [3:0]  dest_q;
  logic [4:0]  sram_q;
  logic [15:0] data_q;
  logic        vld_q;
  logic        last_q;
  logic        err_q;
  logic        me_q;
  logic [15:0] cnt_q;

  logic [15:0] mem [0:63];
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic        sop_take;
  logic [5:0]  ctrl_len;
  logic        unused_ctrl_bits;

  assign ctrl_len         = bus.wr_data[12:7];
  assign unused_ctrl_bits = ^{bus.wr_data[15:13], bus.wr_data[6:4]};
  assign rd_next          = rd_idx + 6'd1;

  always_comb begin
    sop_take = bus.wr_vld && bus.wr_sop && (state == IDLE || state == RECV);
    mem_we   = sop_take || (state == RECV && bus.wr_vld);
    mem_addr = sop_take ? '0 : wr_idx;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      len    <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      dest_q <= '0;
      sram_q <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
      me_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE, RECV: begin
          // A start-of-packet in RECV aborts the old packet and restarts here.
          if (sop_take) begin
            len    <= ctrl_len;
            dest_q <= bus.wr_data[3:0];
            wr_idx <= 6'd1;
            err_q  <= (state == RECV) || (ctrl_len == '0);
            state  <= (ctrl_len == '0) ? IDLE : RECV;
          end else if (state == RECV && bus.wr_vld) begin
            if (bus.wr_eop && wr_idx == len) begin
              state <= MATCH;
              me_q  <= 1'b1;
            end else if (bus.wr_eop || wr_idx == len) begin
              err_q <= 1'b1;
              state <= IDLE;
            end else begin
              wr_idx <= wr_idx + 6'd1;
            end
          end
        end
        MATCH: begin
          // No-SRAM result: drop the request for one cycle, then ask again.
          if (bus.match_suc) begin
            me_q <= 1'b0;
            if (!bus.match_best_sram[5]) begin
              sram_q <= bus.match_best_sram[4:0];
              state  <= XFER;
              rd_idx <= '0;
              data_q <= mem[0];
              vld_q  <= 1'b1;
              last_q <= (len == '0);
            end
          end else if (!me_q) begin
            me_q <= 1'b1;
          end
        end
        XFER: begin
          if (bus.xfer_ready) begin
            if (last_q) begin
              cnt_q  <= cnt_q + 16'd1;
              vld_q  <= 1'b0;
              last_q <= 1'b0;
              state  <= IDLE;
            end else begin
              rd_idx <= rd_next;
              data_q <= mem[rd_next];
              last_q <= (rd_next == len);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state == MATCH) || (state == XFER);
  assign bus.match_enable = me_q;
  assign bus.new_length   = len;
  assign bus.dest_port    = dest_q;
  assign bus.xfer_vld     = vld_q;
  assign bus.xfer_sram    = sram_q;
  assign bus.xfer_data    = data_q;
  assign bus.xfer_last    = last_q;
  assign bus.pkt_err      = err_q;
  assign bus.pkt_cnt      = cnt_q;
endmodule

// File: doc/port_wr_frontend.md
PORT_WR_FRONTEND -- requirements
Module: port_wr_frontend

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, an input of width 1, with all state updated on its rising edge.
REQ-002 The block SHALL have `rst_n`, an input of width 1, which is an asynchronous active-low reset.
REQ-003 `wr_sop` SHALL be an input of width 1 that marks the first halfword of a packet.
REQ-004 `wr_vld` SHALL be an input of width 1 that qualifies `wr_data`.
REQ-005 `wr_data` SHALL be an input of width 16 carrying packet halfwords; the first halfword is the control word.
REQ-006 `wr_eop` SHALL be an input of width 1 that marks the last halfword of a packet.
REQ-007 `busy` SHALL be an output of width 1; when it is 1, the upstream source shall not start a new packet.
REQ-008 `match_enable` SHALL be an output of width 1 that requests an SRAM match from the matcher.
REQ-009 `new_length` SHALL be an output of width 6 giving the packet length in halfwords, excluding the control word.
REQ-010 `dest_port` SHALL be an output of width 4 giving the destination port taken from the control word.
REQ-011 `match_suc` SHALL be an input of width 1 that pulses for one cycle when a match completes.
REQ-012 `match_best_sram` SHALL be an input of width 6 and SHALL be valid while `match_suc` is 1; the value 32 means no SRAM.
REQ-013 `xfer_vld` SHALL be an output of width 1 that qualifies an SRAM write halfword.
REQ-014 `xfer_sram` SHALL be an output of width 5 giving the target SRAM index.
REQ-015 `xfer_data` SHALL be an output of width 16 giving the halfword being written.
REQ-016 `xfer_last` SHALL be an output of width 1 that marks the final halfword of a transfer.
REQ-017 `xfer_ready` SHALL be an input of width 1; a handshake occurs when `xfer_vld` and `xfer_ready` are both 1.
REQ-018 `pkt_err` SHALL be an output of width 1 that pulses for one cycle when a packet is dropped.
REQ-019 `pkt_cnt` SHALL be an output of width 16 counting packets that were fully transferred.

Function
REQ-020 The control word SHALL be decoded as: bits [3:0] are `dest_port`; bits [6:4] are priority, which is carried but not used; bits [12:7] are the length L.
REQ-021 The block SHALL contain a 64x16 packet buffer in which index 0 holds the control word and indices 1..L hold the data halfwords.
REQ-022 The block SHALL implement four states, IDLE, RECV, MATCH and XFER, and the state SHALL reset to IDLE.
REQ-023 In IDLE, a cycle with `wr_vld` and `wr_sop` both 1 SHALL store the word to buffer index 0 and latch L and `dest_port`.
REQ-024 After the action in REQ-023, the next state SHALL be RECV if L is nonzero.
REQ-025 After the action in REQ-023, if L is 0 the block SHALL drop the packet, pulse `pkt_err`, and remain in IDLE.
REQ-026 In IDLE, a cycle with `wr_vld` equal to 1 and `wr_sop` equal to 0 SHALL be ignored.
REQ-027 In RECV, each `wr_vld` cycle SHALL write the word at the next index, and the write index SHALL increment by 1.
REQ-028 In RECV, a `wr_eop` that arrives on the word at index L SHALL move the state to MATCH.
REQ-029 In RECV, `wr_eop` arriving at an index other than L, or no `wr_eop` by index L, SHALL drop the packet, pulse `pkt_err` and return to IDLE.
REQ-030 In RECV, a `wr_sop` SHALL abort the current packet with a `pkt_err` pulse and SHALL start the new packet as if from IDLE in the same cycle.
REQ-031 In MATCH, `match_enable` SHALL be 1, and `new_length` and `dest_port` SHALL be held stable.
REQ-032 `match_enable` SHALL rise in the first MATCH cycle, which is one cycle after the `wr_eop` cycle.
REQ-033 In MATCH, `match_suc` equal to 1 with `match_best_sram[5]` equal to 0 SHALL latch `match_best_sram[4:0]` into `xfer_sram` and move the state to XFER.
REQ-034 `match_enable` SHALL be 0 in the cycle after `match_suc` is sampled.
REQ-035 In MATCH, `match_suc` equal to 1 with `match_best_sram` equal to 32 SHALL drop `match_enable` for exactly one cycle and then re-request the match; `pkt_err` SHALL NOT pulse in this case.
REQ-036 In XFER, the block SHALL present buffer indices 0..L in order and advance only on a handshake.
REQ-037 In XFER, `xfer_data` and `xfer_vld` SHALL be held stable while `xfer_ready` is 0.
REQ-038 `xfer_last` SHALL be 1 only while index L is being presented.
REQ-039 The handshake at index L SHALL increment `pkt_cnt`, with wrap-around from 65535 to 0, and SHALL return the state to IDLE.
REQ-040 The first XFER word SHALL appear in the cycle after `match_suc`, and a fully ready transfer SHALL take L+1 cycles.
REQ-041 `busy` SHALL be 1 in the MATCH and XFER states and 0 in the IDLE and RECV states.
REQ-042 Input activity during MATCH or XFER SHALL be ignored.

Reset
REQ-043 When `rst_n` is 0, asynchronously: state SHALL be IDLE; `busy`, `match_enable`, `xfer_vld`, `xfer_last` and `pkt_err` SHALL be 0.
REQ-044 When `rst_n` is 0: `new_length`, `dest_port`, `xfer_sram`, `xfer_data`, `pkt_cnt` and all indices SHALL be 0; buffer contents are not reset.
REQ-045 Reset asserted in any state SHALL abandon the packet without a `pkt_err` pulse, and after release the block SHALL accept a new `wr_sop` on the first clock.

Verification
REQ-046 Scenario normal path: control word L=3, dest=5, then 3 data words with `wr_eop`, `match_suc` 4 cycles later with SRAM 7, `xfer_ready` held 1 -> `match_enable` is high from the cycle after `wr_eop` until `match_suc`; 4 xfer words go to SRAM 7 with `xfer_last` on the 4th; `pkt_cnt` becomes 1.
REQ-047 Scenario early eop: L=4 with `wr_eop` on data word 2 -> `pkt_err` pulses once, the state is IDLE, and `match_enable` never rises.
REQ-048 Scenario backpressure: `xfer_ready` toggles 1,0,0,1 during XFER -> `xfer_data` is stable while stalled, all L+1 words are delivered in order, and no word is duplicated.
REQ-049 Scenario no-SRAM result: `match_suc` with `match_best_sram` equal to 32 -> `match_enable` is low for 1 cycle and then high again; a second `match_suc` with SRAM 2 -> transfer to SRAM 2 proceeds.
REQ-050 Scenario mid-packet restart: `wr_sop` arrives while in RECV -> one `pkt_err` pulse, after which the new packet completes normally.
REQ-051 Scenario reset during XFER: reset asserted at word 2 -> outputs are 0 immediately and `pkt_cnt` is 0; a packet after release transfers correctly.
